// File: rtl/data_memory_hs.sv
// Single-port synchronous data memory with valid/ready request channel, registered read
// response with backpressure and a post-reset zero sweep. Optional: DATA_MEMORY_BOUNDS_CHECK_EN.
module data_memory_hs #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  output logic              err,
`endif
  output logic              init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              oob;
  logic              acc;
  logic              rd_acc;
  logic              wr_acc;

  assign idx = req_addr[IDX_W-1:0];

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic err_q;
  assign oob = (32'(req_addr) >= DEPTH);
  assign err = err_q;
`else
  // Upper address bits are intentionally ignored so addresses wrap modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^req_addr;
  assign oob         = 1'b0;
`endif

  assign acc    = req_valid && req_ready;
  assign rd_acc = acc && !req_write;
  assign wr_acc = acc && req_write && !oob;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      sweep_idx_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StInit: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StInit;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = 1'b0;
    if (state_q == StRun) begin
      req_ready = !rsp_valid_q || rsp_ready;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

  // Array has no reset; the sweep clears it after every reset release.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[sweep_idx_q] <= '0;
    end else if (wr_acc) begin
      mem[idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (rd_acc) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= oob ? '0 : mem[idx];
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= acc && oob;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed self-checking bench for data_memory_hs (DEPTH=8, DATA_W=16).
module tb_data_memory_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        init_done;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_hs #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    .err      (err),
`endif
    .init_done(init_done)
  );

  // Inputs change and outputs are observed on the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_ready addr=%h: got %b expected 1", addr, req_ready);
    end
    cycle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    cycle();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      errors++;
      $display("FAIL %s addr=%h: got valid=%b data=%h expected valid=1 data=%h",
               name, addr, rsp_valid, rsp_rdata, exp);
    end
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < 20) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_ready_low cycle=%0d: got %b expected 0", name, n, req_ready);
      end
      cycle();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s_len: got %0d cycles expected 8", name, n);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_high: got %b expected 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || init_done !== 1'b0)
    begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%h done=%b expected 0 0 0000 0",
               req_ready, rsp_valid, rsp_rdata, init_done);
    end
    rst = 1'b0;
    wait_init("init_sweep");
  endtask

  task automatic test_init_zero();
    for (int i = 0; i < 8; i++) begin
      do_read(16'(i), 16'h0000, "init_zero");
    end
    cycle();
  endtask

  task automatic test_write_read();
    do_write(16'h0003, 16'hA5A5);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rsp: got %b expected 0", rsp_valid);
    end
    do_read(16'h0003, 16'hA5A5, "write_read");
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [3];
    exp[0] = 16'h0011;
    exp[1] = 16'h0022;
    exp[2] = 16'h0033;
    for (int i = 0; i < 3; i++) do_write(16'(i), exp[i]);
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 16'(i);
      cycle();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back %0d: got valid=%b data=%h expected valid=1 data=%h",
                 i, rsp_valid, rsp_rdata, exp[i]);
      end
    end
    req_valid = 1'b0;
    cycle();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    do_read(16'h0001, 16'h0022, "bp_first");
    // Hold a second read request; it must not be taken while stalled.
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 16'h0022) begin
        errors++;
        $display("FAIL bp_hold %0d: got ready=%b valid=%b data=%h expected 0 1 0022",
                 i, req_ready, rsp_valid, rsp_rdata);
      end
      cycle();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", req_ready);
    end
    cycle();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0011) begin
      errors++;
      $display("FAIL bp_same_cycle: got valid=%b data=%h expected valid=1 data=0011",
               rsp_valid, rsp_rdata);
    end
    cycle();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0011) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b data=%h expected valid=0 data=0011",
               rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_write_pending();
    do_read(16'h0002, 16'h0033, "wp_read");
    do_write(16'h0000, 16'h7777);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0033) begin
      errors++;
      $display("FAIL write_pending: got valid=%b data=%h expected valid=0 data=0033",
               rsp_valid, rsp_rdata);
    end
    do_read(16'h0000, 16'h7777, "wp_readback");
    cycle();
  endtask

  task automatic test_wrap();
    do_write(16'h000B, 16'hBEEF);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL oob_write_err: got %b expected 1", err);
    end
    cycle();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL oob_err_pulse: got %b expected 0", err);
    end
    do_read(16'h0003, 16'hA5A5, "oob_write_dropped");
    do_read(16'h000B, 16'h0000, "oob_read_zero");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL oob_read_err: got %b expected 1", err);
    end
`else
    do_read(16'h0003, 16'hBEEF, "wrap");
    do_read(16'h00F3, 16'hBEEF, "wrap_high");
`endif
    cycle();
  endtask

  task automatic test_reset_mid();
    do_write(16'h0005, 16'h1234);
    rsp_ready = 1'b0;
    do_read(16'h0005, 16'h1234, "mid_pre");
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got valid=%b done=%b expected 0 0", rsp_valid, init_done);
    end
    cycle();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    wait_init("mid_sweep");
    do_read(16'h0005, 16'h0000, "mid_cleared");
    do_read(16'h0003, 16'h0000, "mid_cleared3");
    cycle();
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_write_pending();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
Parametrised, single-port synchronous data memory for the RISC datapath. It replaces the fixed 16-bit, 8-entry, combinational-read store with a configurable block that has the following features:
- a valid/ready request channel;
- a registered read response with backpressure;
- a hardware zero-initialisation sweep after reset.

It sits between the load/store stage and the memory array. The LSU stalls on req_ready.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, request address width in bits
DEPTH, 8, number of words; power of two, 2..65536
IDX_W, $clog2(DEPTH), index width; derived, do not override

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address; index = req_addr[IDX_W-1:0]
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready
rsp_rdata  output  DATA_W  read data; held stable while rsp_valid && !rsp_ready
init_done  output  1  high once the zero sweep has completed

Behaviour:
Reset (asynchronous assert, synchronous release):
- state=INIT, sweep_idx=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- Memory contents are not reset directly; the INIT sweep clears them.

INIT state:
- Writes 0 to memory[sweep_idx] each cycle and increments sweep_idx.
- After writing index DEPTH-1: go to RUN and set init_done=1.
- The sweep takes exactly DEPTH cycles after reset release.
- Requests are ignored during INIT (req_ready=0).

RUN state:
- req_ready = !rsp_valid || rsp_ready (combinational from registered state plus rsp_ready).
- Accepted write: memory[index] <= req_wdata at the same edge. No response is generated.
- Accepted read: at the next edge, rsp_rdata <= memory[index] and rsp_valid <= 1. Latency is 1 cycle.
- Response handshake with no new read accepted: rsp_valid <= 0 and rsp_rdata holds its value.
- Response handshake in the same cycle a new read is accepted: rsp_valid stays 1 and rsp_rdata updates. This gives full throughput of 1 read per cycle.
- A write accepted while a response is pending (only possible when rsp_ready=1) leaves rsp_rdata unaffected.
- Read after a write to the same index on the next cycle returns the new data. Same-cycle read and write cannot occur (single request per cycle).
- Upper address bits above IDX_W are ignored, so addresses wrap modulo DEPTH.

Reset mid-operation:
- Any pending response is dropped.
- The sweep restarts from 0 and all prior contents are cleared.

No X propagation: rsp_rdata is only loaded from initialised memory.

Optional Feature:
Macro DATA_MEMORY_BOUNDS_CHECK_EN.
- Defined:
  - Extra output port err  output  1, reset 0.
  - A request with req_addr >= DEPTH is still accepted (handshake unchanged).
  - An out-of-range write is dropped.
  - An out-of-range read returns rsp_rdata=0 with rsp_valid=1.
  - err pulses high for one cycle after any out-of-range acceptance.
- Undefined: the err port is absent and addresses wrap as described above.

Test Plan:
- Reset release, DEPTH=8: req_ready=0 for 8 cycles and init_done rises on cycle 8. Then read each of addr 0..7: all return 16'h0000.
- Write 16'hA5A5 to addr 3, then read addr 3 on the next cycle: rsp_valid one cycle after acceptance, rsp_rdata=16'hA5A5.
- Reads to addr 0,1,2 back-to-back with rsp_ready held 1 (after writing 16'h0011, 16'h0022, 16'h0033): three consecutive rsp_valid cycles carrying 0011, 0022, 0033.
- Read addr 1 with rsp_ready=0 for 4 cycles: req_ready=0, and rsp_rdata holds 16'h0022 with rsp_valid=1 until rsp_ready=1; then req_ready returns to 1.
- Write 16'hBEEF to addr 16'h000B, then read addr 3: returns BEEF (wrap). With DATA_MEMORY_BOUNDS_CHECK_EN defined: err pulses, the write is dropped, and the read of addr 3 returns the prior value.
- Assert rst while rsp_valid=1 after writing 16'h1234 to addr 5: rsp_valid drops immediately, the sweep reruns, and a read of addr 5 afterwards returns 16'h0000.
